clock_blink_multi: RTL
======================

# clock_blink_multi

Multi-channel blink generator for the clock display's edit fields. It replaces the single-channel, 1 s-only blinker. Each of NUM_CH channels independently selects OFF, ON, SLOW blink (toggled by the shared 1 s event) or FAST blink (toggled by an internal divider). A per-channel kick input forces the field visible while the user is adjusting it. Sits between the setting FSM (drives mode/kick) and the digit blanking logic (consumes blink).

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz
- FAST_TOGGLE_HZ, 4, FAST-mode toggle rate; FAST_DIV = CLK_HZ/FAST_TOGGLE_HZ, elaboration error unless CLK_HZ % FAST_TOGGLE_HZ == 0 and FAST_DIV >= 2
- NUM_CH, 4, number of channels, 1..16

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- event_clk1s  in  1  one-cycle pulse, once per second
- mode  in  2*NUM_CH  channel i mode at [2i+1:2i]: 0 OFF, 1 ON, 2 SLOW, 3 FAST
- kick  in  NUM_CH  one-cycle pulse per channel, restart visible phase
- blink  out  NUM_CH  registered visibility, 1 = field shown
- fast_tick  out  1  registered one-cycle pulse each FAST_DIV cycles

## Operation
- Divider: counter 0..FAST_DIV-1, free-running, wraps to 0. fast_tick=1 for the cycle after the counter holds FAST_DIV-1.
- Per channel state: blink (phase) register, skip flag, registered previous mode.
- Channel toggle event: SLOW uses event_clk1s, FAST uses the internal terminal count, the same cycle fast_tick is asserted next.
- Per-channel priority, highest first, evaluated every cycle:
  1. rst: blink=0, skip=0, prev mode=OFF.
  2. mode OFF: blink=0, skip=0. mode ON: blink=1, skip=0. kick is ignored in both.
  3. Entry into SLOW/FAST from a different mode, including SLOW<->FAST: blink=1. skip = kick.
  4. kick in SLOW/FAST: blink=1, skip=1. This overrides a coincident toggle event.
  5. Toggle event with skip=1: skip=0, blink unchanged.
  6. Toggle event with skip=0: blink = ~blink.
  7. Otherwise hold.
- The kick-then-skip rule guarantees at least one full toggle interval visible after the last kick.
- Channels are fully independent. Channels in the same mode share phase unless kicked or entered at different times.
- event_clk1s is used as-is, with no edge detection. A multi-cycle high toggles on each cycle; the source is required to be a pulse.

## Timing
- Reset values: blink = all 0, fast_tick = 0, divider = 0, all skip = 0.
- Latency: mode/kick/event sampled at edge N, blink reflects the result after edge N (one register stage). No combinational input-to-output path.
- The first fast_tick after reset release occurs FAST_DIV cycles after the first non-reset edge. Period is exactly FAST_DIV cycles.
- Mode change mid-blink takes effect in one cycle. Reset asserted mid-operation clears everything on the next edge regardless of other inputs.

## Structure
- Shared package clock_blink_pkg:
  - blink_mode_t 2-bit enum: BLK_OFF=0, BLK_ON=1, BLK_SLOW=2, BLK_FAST=3.
  - Function computing FAST_DIV and its counter width ($clog2).
- Sub-module clock_blink_fast_tick: parametrised divider, ports clk, rst, tick. Instantiated once.
- Channel logic is a generate loop in the top. No per-channel sub-module.

## Test plan
Bench uses CLK_HZ=16, FAST_TOGGLE_HZ=4, so FAST_DIV=4.
- Reset/divider: hold rst 3 cycles, release. blink=0000 and fast_tick=0 during reset; fast_tick high on cycles 4, 8, 12 after release, never two in a row.
- Modes: mode ch0..3 = OFF, ON, SLOW, FAST.
  - blink = 0b1110 one cycle later.
  - ch3 toggles right after each fast_tick.
  - ch2 toggles only after each event_clk1s pulse (pulse every 16 cycles).
  - ch0 stays 0, ch1 stays 1.
- Kick: ch2 SLOW with blink=0, kick ch2.
  - blink[2]=1 next cycle.
  - Next event_clk1s leaves it 1; the following event drives it 0.
- Coincidence: kick ch3 in the same cycle as the FAST terminal count.
  - blink[3]=1, the tick is consumed as skip, and the next tick does not toggle.
- Mode switch: ch3 FAST with blink=0, switch to SLOW.
  - blink[3]=1 next cycle, then no toggles until event_clk1s.
  - Switch to OFF: 0 within one cycle.
- Reset mid-operation: assert rst during active blinking with pending skips.
  - All outputs 0 next cycle.
  - After release, the first SLOW event toggles immediately (skip was cleared).

Source files
------------

// File: rtl/clock_blink_pkg.sv
// Shared types and divider sizing helpers for the multi-channel blinker.
package clock_blink_pkg;

    typedef enum logic [1:0] {
        BLK_OFF  = 2'd0,
        BLK_ON   = 2'd1,
        BLK_SLOW = 2'd2,
        BLK_FAST = 2'd3
    } blink_mode_t;

    // Number of system clocks between FAST toggles.
    function automatic int fast_div_calc(input int clk_hz, input int toggle_hz);
        return clk_hz / toggle_hz;
    endfunction

    // Counter width needed to hold 0..div-1 (at least one bit).
    function automatic int fast_cnt_width(input int div);
        return ($clog2(div) < 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/clock_blink_fast_tick.sv
// Free-running divider; tick flags the cycle the counter holds DIV-1.
module clock_blink_fast_tick
    import clock_blink_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int W = fast_cnt_width(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    // Count 0..DIV-1 and wrap; held at 0 while in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Terminal count; the top registers this into fast_tick.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/clock_blink_multi.sv
// Multi-channel blink generator for clock edit fields (OFF/ON/SLOW/FAST + kick).
module clock_blink_multi
    import clock_blink_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int FAST_TOGGLE_HZ = 4,
    parameter int NUM_CH         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  event_clk1s,
    input  logic [2*NUM_CH-1:0]   mode,
    input  logic [NUM_CH-1:0]     kick,
    output logic [NUM_CH-1:0]     blink,
    output logic                  fast_tick
);

    localparam int FAST_DIV = fast_div_calc(CLK_HZ, FAST_TOGGLE_HZ);

    if ((CLK_HZ % FAST_TOGGLE_HZ) != 0 || FAST_DIV < 2) begin : g_bad_div
        $error("clock_blink_multi: CLK_HZ must be a multiple of FAST_TOGGLE_HZ with ratio >= 2");
    end
    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_ch
        $error("clock_blink_multi: NUM_CH must be 1..16");
    end

    logic fast_tc;

    clock_blink_fast_tick #(
        .DIV (FAST_DIV)
    ) u_fast_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (fast_tc)
    );

    // fast_tick is the terminal count delayed by one register stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            fast_tick <= 1'b0;
        end else begin
            fast_tick <= fast_tc;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        blink_mode_t cur_mode;
        blink_mode_t prev_mode;
        logic        skip;
        logic        phase;
        logic        toggle_ev;

        assign cur_mode  = blink_mode_t'(mode[2*i +: 2]);
        // FAST toggles on the same edge that raises fast_tick.
        assign toggle_ev = (cur_mode == BLK_FAST) ? fast_tc : event_clk1s;
        assign blink[i]  = phase;

        // Per-channel priority: mode forcing, blink entry, kick, skipped toggle, toggle.
        always_ff @(posedge clk) begin
            if (rst) begin
                phase     <= 1'b0;
                skip      <= 1'b0;
                prev_mode <= BLK_OFF;
            end else begin
                prev_mode <= cur_mode;
                case (cur_mode)
                    BLK_OFF: begin
                        phase <= 1'b0;
                        skip  <= 1'b0;
                    end
                    BLK_ON: begin
                        phase <= 1'b1;
                        skip  <= 1'b0;
                    end
                    BLK_SLOW, BLK_FAST: begin
                        if (prev_mode != cur_mode) begin
                            phase <= 1'b1;
                            skip  <= kick[i];
                        end else if (kick[i]) begin
                            phase <= 1'b1;
                            skip  <= 1'b1;
                        end else if (toggle_ev) begin
                            if (skip) begin
                                skip <= 1'b0;
                            end else begin
                                phase <= ~phase;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule
